// File: rtl/eeprom_ctrl_if.sv
// Request/response bundle between a bus or test master and eeprom_ctrl.
// The master drives requests and the controller returns a one-cycle response pulse.
interface eeprom_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/eeprom_ctrl.sv
// Sequences read/write/erase requests onto a level-sensitive EEPROM array.
// Writes run as a timed erase phase followed by a timed program phase.
module eeprom_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int ERASE_CYCLES = 4,
  parameter int PROG_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  eeprom_ctrl_if.slave      bus,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_erase,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MAX_CYC = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ERASE,
    S_PROG,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_rsp_valid;
  logic              r_we;
  logic              r_erase;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_idle;

  assign w_idle        = (r_state == S_IDLE);
  assign bus.req_ready = w_idle;
  assign busy          = !w_idle;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign mem_we        = r_we;
  assign mem_erase     = r_erase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_we        <= 1'b0;
      r_erase     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op    <= bus.req_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
            case (bus.req_op)
              2'b00: r_state <= S_READ;
              2'b01, 2'b10: begin
                r_state <= S_ERASE;
                r_erase <= 1'b1;
                r_cnt   <= CNT_W'(ERASE_CYCLES);
              end
              default: begin
                r_state     <= S_DONE;
                r_err       <= 1'b1;
                r_rsp_valid <= 1'b1;
              end
            endcase
          end
        end
        S_READ: begin
          r_rdata     <= mem_rdata;
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
        end
        S_ERASE: begin
          // Counter is loaded with the full phase length on entry, so the
          // phase ends in the cycle where it reads 1.
          if (r_cnt == CNT_W'(1)) begin
            r_erase <= 1'b0;
            if (r_op == 2'b01) begin
              r_state <= S_PROG;
              r_we    <= 1'b1;
              r_cnt   <= CNT_W'(PROG_CYCLES);
            end else begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_cnt       <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_PROG: begin
          if (r_cnt == CNT_W'(1)) begin
            r_we        <= 1'b0;
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
